// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared command/state types, decoded request layout and default geometry/timing
package mem_ctrl_pkg;
  localparam int DEF_BANK_GROUPS = 2;
  localparam int DEF_BANKS_PER_GROUP = 4;
  localparam int DEF_ROW_BITS = 8;
  localparam int DEF_COL_BITS = 4;
  localparam int DEF_PADDR_BITS = 64;
  localparam int DEF_ACTIVATION_LATENCY = 8;
  localparam int DEF_PRECHARGE_LATENCY = 5;
  localparam int DEF_CAS_LATENCY = 22;
  localparam int DEF_BURST_GAP = 4;
  localparam int DEF_BG_BITS = $clog2(DEF_BANK_GROUPS);
  localparam int DEF_BA_BITS = $clog2(DEF_BANKS_PER_GROUP);
  typedef enum logic [2:0] {
    CMD_READ = 3'd0,
    CMD_WRITE = 3'd1,
    CMD_ACTIVATE = 3'd2,
    CMD_PRECHARGE = 3'd3
  } cmd_t;
  typedef enum logic [2:0] {IDLE, CHECK, PRE, WAIT_PRE, ACT, WAIT_ACT, CAS} state_t;
  typedef struct packed {
    logic write;
    logic [DEF_BG_BITS-1:0] bg;
    logic [DEF_BA_BITS-1:0] ba;
    logic [DEF_ROW_BITS-1:0] row;
    logic [DEF_COL_BITS-1:0] col;
  } req_t;
endpackage

// File: rtl/address_parser.sv
// address_parser: splits a physical address into column, bank, bank group and row fields
module address_parser #(
  parameter int PADDR_BITS = 64,
  parameter int COL_BITS = 4,
  parameter int BA_BITS = 2,
  parameter int BG_BITS = 1,
  parameter int ROW_BITS = 8
) (
  input logic [PADDR_BITS-1:0] addr,
  output logic [COL_BITS-1:0] col,
  output logic [BA_BITS-1:0] ba,
  output logic [BG_BITS-1:0] bg,
  output logic [ROW_BITS-1:0] row
);
  localparam int BA_LO = 3 + COL_BITS;
  localparam int BG_LO = BA_LO + BA_BITS;
  localparam int ROW_LO = BG_LO + BG_BITS;
  localparam int TOP = ROW_LO + ROW_BITS;
  logic unused_bits;
  assign col = addr[BA_LO-1:3];
  assign ba = addr[BG_LO-1:BA_LO];
  assign bg = addr[ROW_LO-1:BG_LO];
  assign row = addr[TOP-1:ROW_LO];
  assign unused_bits = ^{addr[2:0], addr[PADDR_BITS-1:TOP]};
endmodule

// File: rtl/bank_state_table.sv
// bank_state_table: per-bank open-row record with one combinational lookup and one set/invalidate port
module bank_state_table #(
  parameter int IDX_BITS = 3,
  parameter int ROW_BITS = 8
) (
  input logic clk,
  input logic rst_n,
  input logic [IDX_BITS-1:0] idx,
  output logic hit_valid,
  output logic [ROW_BITS-1:0] hit_row,
  input logic we,
  input logic set,
  input logic [ROW_BITS-1:0] wr_row
);
  localparam int N = 2 ** IDX_BITS;
  logic [N-1:0] valid_q;
  logic [ROW_BITS-1:0] row_q [N];
  assign hit_valid = valid_q[idx];
  assign hit_row = row_q[idx];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) row_q[i] <= '0;
    end else if (we) begin
      valid_q[idx] <= set;
      if (set) row_q[idx] <= wr_row;
    end
endmodule

// File: rtl/bank_cmd_issuer.sv
// bank_cmd_issuer: turns one request at a time into PRE/ACT/RD/WR commands under bank and bus timing
module bank_cmd_issuer
  import mem_ctrl_pkg::*;
#(
  parameter int BANK_GROUPS = DEF_BANK_GROUPS,
  parameter int BANKS_PER_GROUP = DEF_BANKS_PER_GROUP,
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int COL_BITS = DEF_COL_BITS,
  parameter int PADDR_BITS = DEF_PADDR_BITS,
  parameter int ACTIVATION_LATENCY = DEF_ACTIVATION_LATENCY,
  parameter int PRECHARGE_LATENCY = DEF_PRECHARGE_LATENCY,
  parameter int CAS_LATENCY = DEF_CAS_LATENCY,
  parameter int BURST_GAP = DEF_BURST_GAP
) (
  input logic clk_in,
  input logic rst_N_in,
  input logic req_valid_in,
  output logic req_ready_out,
  input logic req_write_in,
  input logic [PADDR_BITS-1:0] req_addr_in,
  input logic [7:0][63:0] req_data_in,
  input logic bursting_in,
  output logic cmd_valid_out,
  output logic [2:0] cmd_out,
  output logic [$clog2(BANK_GROUPS)-1:0] bank_group_out,
  output logic [$clog2(BANKS_PER_GROUP)-1:0] bank_out,
  output logic [ROW_BITS-1:0] row_out,
  output logic [COL_BITS-1:0] col_out,
  output logic [7:0][63:0] val_out,
  output logic idle_out
);
  localparam int BGW = $clog2(BANK_GROUPS);
  localparam int BAW = $clog2(BANKS_PER_GROUP);
  localparam int TW = BGW + BAW + ROW_BITS + COL_BITS;
  localparam int CW = $clog2(CAS_LATENCY + BURST_GAP + ACTIVATION_LATENCY + PRECHARGE_LATENCY);
  localparam logic [CW-1:0] ONE = CW'(1);
  state_t state_q, state_d;
  req_t req_q, req_d;
  cmd_t cmd_q, cmd_d;
  logic [7:0][63:0] data_q, data_d, val_q, val_d;
  logic [CW-1:0] wait_q, wait_d, gap_q, gap_d, rd_turn_q, rd_turn_d;
  logic [TW-1:0] tgt_q, tgt_d;
  logic cmd_valid_q, cmd_valid_d;
  logic [BGW-1:0] p_bg;
  logic [BAW-1:0] p_ba;
  logic [ROW_BITS-1:0] p_row;
  logic [COL_BITS-1:0] p_col;
  logic hit_valid, tbl_we, tbl_set, cas_ok;
  logic [ROW_BITS-1:0] hit_row;
  address_parser #(
    .PADDR_BITS(PADDR_BITS),
    .COL_BITS(COL_BITS),
    .BA_BITS(BAW),
    .BG_BITS(BGW),
    .ROW_BITS(ROW_BITS)
  ) u_parser (
    .addr(req_addr_in),
    .col(p_col),
    .ba(p_ba),
    .bg(p_bg),
    .row(p_row)
  );
  bank_state_table #(
    .IDX_BITS(BGW + BAW),
    .ROW_BITS(ROW_BITS)
  ) u_table (
    .clk(clk_in),
    .rst_n(rst_N_in),
    .idx({req_q.bg, req_q.ba}),
    .hit_valid(hit_valid),
    .hit_row(hit_row),
    .we(tbl_we),
    .set(tbl_set),
    .wr_row(req_q.row)
  );
  assign req_ready_out = state_q == IDLE;
  assign idle_out = state_q == IDLE && !req_valid_in;
  assign cmd_valid_out = cmd_valid_q;
  assign cmd_out = cmd_q;
  assign {bank_group_out, bank_out, row_out, col_out} = tgt_q;
  assign val_out = val_q;
  assign cas_ok = !bursting_in && gap_q == '0 && !(req_q.write && rd_turn_q != '0);
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    data_d = data_q;
    val_d = val_q;
    cmd_d = cmd_q;
    cmd_valid_d = 1'b0;
    wait_d = wait_q == '0 ? '0 : wait_q - ONE;
    gap_d = gap_q == '0 ? '0 : gap_q - ONE;
    rd_turn_d = rd_turn_q == '0 ? '0 : rd_turn_q - ONE;
    tbl_we = 1'b0;
    tbl_set = 1'b0;
    case (state_q)
      IDLE: if (req_valid_in) begin
        req_d = '{write: req_write_in, bg: p_bg, ba: p_ba, row: p_row, col: p_col};
        data_d = req_data_in;
        state_d = CHECK;
      end
      CHECK: state_d = !hit_valid ? ACT : hit_row == req_q.row ? CAS : PRE;
      PRE: begin
        cmd_valid_d = 1'b1;
        cmd_d = CMD_PRECHARGE;
        tbl_we = 1'b1;
        wait_d = CW'(PRECHARGE_LATENCY - 1);
        state_d = WAIT_PRE;
      end
      WAIT_PRE: state_d = wait_q <= ONE ? ACT : WAIT_PRE;
      ACT: begin
        cmd_valid_d = 1'b1;
        cmd_d = CMD_ACTIVATE;
        tbl_we = 1'b1;
        tbl_set = 1'b1;
        wait_d = CW'(ACTIVATION_LATENCY - 1);
        state_d = WAIT_ACT;
      end
      WAIT_ACT: state_d = wait_q <= ONE ? CAS : WAIT_ACT;
      CAS: if (cas_ok) begin
        cmd_valid_d = 1'b1;
        cmd_d = req_q.write ? CMD_WRITE : CMD_READ;
        val_d = data_q;
        gap_d = CW'(BURST_GAP - 1);
        rd_turn_d = req_q.write ? rd_turn_d : CW'(CAS_LATENCY + BURST_GAP - 1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    tgt_d = cmd_valid_d ? {req_q.bg, req_q.ba, req_q.row, req_q.col} : tgt_q;
  end
  always_ff @(posedge clk_in or negedge rst_N_in)
    if (!rst_N_in) begin
      state_q <= IDLE;
      req_q <= '0;
      data_q <= '0;
      val_q <= '0;
      cmd_q <= CMD_READ;
      cmd_valid_q <= 1'b0;
      wait_q <= '0;
      gap_q <= '0;
      rd_turn_q <= '0;
      tgt_q <= '0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      data_q <= data_d;
      val_q <= val_d;
      cmd_q <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      wait_q <= wait_d;
      gap_q <= gap_d;
      rd_turn_q <= rd_turn_d;
      tgt_q <= tgt_d;
    end
endmodule

// File: tb/tb_bank_cmd_issuer.sv
// tb_bank_cmd_issuer: predicts command times and fields from the timing rules and compares each strobe
module tb_bank_cmd_issuer;
  localparam int ACT_L = 8;
  localparam int PRE_L = 5;
  localparam int CL = 22;
  localparam int GAP = 4;
  typedef struct {
    int t;
    logic [2:0] c;
    logic bg;
    logic [1:0] ba;
    logic [7:0] row;
    logic [3:0] col;
  } ev_t;
  logic clk_in = 1'b0;
  logic rst_N_in = 1'b0;
  logic req_valid_in = 1'b0;
  logic req_write_in = 1'b0;
  logic bursting_in = 1'b0;
  logic [63:0] req_addr_in = '0;
  logic [7:0][63:0] req_data_in = '0;
  logic req_ready_out, cmd_valid_out, idle_out, bank_group_out;
  logic [2:0] cmd_out;
  logic [1:0] bank_out;
  logic [7:0] row_out;
  logic [3:0] col_out;
  logic [7:0][63:0] val_out;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  ev_t evq[$];
  logic open_v [8];
  logic [7:0] open_r [8];
  int last_cas = -1000;
  int last_rd = -1000;
  bank_cmd_issuer dut (
    .clk_in(clk_in),
    .rst_N_in(rst_N_in),
    .req_valid_in(req_valid_in),
    .req_ready_out(req_ready_out),
    .req_write_in(req_write_in),
    .req_addr_in(req_addr_in),
    .req_data_in(req_data_in),
    .bursting_in(bursting_in),
    .cmd_valid_out(cmd_valid_out),
    .cmd_out(cmd_out),
    .bank_group_out(bank_group_out),
    .bank_out(bank_out),
    .row_out(row_out),
    .col_out(col_out),
    .val_out(val_out),
    .idle_out(idle_out)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  always @(posedge clk_in) begin
    #1;
    if (cmd_valid_out === 1'b1)
      evq.push_back('{cyc, cmd_out, bank_group_out, bank_out, row_out, col_out});
  end
  function automatic logic [63:0] mk_addr(input logic bg, input logic [1:0] ba, input logic [7:0] row, input logic [3:0] col);
    logic [45:0] hi;
    logic [2:0] lo;
    hi = {$urandom, 14'($urandom)};
    lo = 3'($urandom);
    return {hi, row, bg, ba, col, lo};
  endfunction
  task automatic apply_reset;
    rst_N_in = 1'b0;
    req_valid_in = 1'b0;
    bursting_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_N_in = 1'b1;
    for (int i = 0; i < 8; i++) open_v[i] = 1'b0;
    last_cas = -1000;
    last_rd = -1000;
    evq.delete();
  endtask
  task automatic check_reset_outputs(input string name);
    n_chk++;
    if ({req_ready_out, idle_out, cmd_valid_out, cmd_out, bank_group_out, bank_out, row_out, col_out} !== {2'b11, 19'b0}) begin
      n_fail++;
      $display("FAIL %s: ready=%b idle=%b valid=%b cmd=%0d bg=%b ba=%0d row=%0d col=%0d, required ready=1 idle=1 rest 0",
               name, req_ready_out, idle_out, cmd_valid_out, cmd_out, bank_group_out, bank_out, row_out, col_out);
    end
    n_chk++;
    if (val_out !== '0) begin
      n_fail++;
      $display("FAIL %s_val: val_out=%h, required 0", name, val_out);
    end
  endtask
  task automatic do_req(input logic bg, input logic [1:0] ba, input logic [7:0] row, input logic [3:0] col, input logic wr, input int burst);
    ev_t exp_q[$];
    ev_t ev;
    logic [7:0][63:0] d;
    int k, e0, t, cas, idx;
    for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
    k = 0;
    while (req_ready_out !== 1'b1 && k < 100) begin
      @(negedge clk_in);
      k++;
    end
    n_chk++;
    if (req_ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_wait: req_ready_out=%b, required 1", req_ready_out);
    end
    req_valid_in = 1'b1;
    req_write_in = wr;
    req_data_in = d;
    req_addr_in = mk_addr(bg, ba, row, col);
    e0 = cyc + 1;
    @(negedge clk_in);
    req_valid_in = 1'b0;
    req_write_in = ~wr;
    req_addr_in = {$urandom, $urandom};
    for (int i = 0; i < 8; i++) req_data_in[i] = {$urandom, $urandom};
    n_chk++;
    if ({req_ready_out, idle_out} !== 2'b00) begin
      n_fail++;
      $display("FAIL busy_flags: ready=%b idle=%b, required 0 0", req_ready_out, idle_out);
    end
    if (burst > 0) begin
      bursting_in = 1'b1;
      repeat (burst) @(negedge clk_in);
      bursting_in = 1'b0;
    end
    idx = int'({bg, ba});
    t = e0 + 2;
    if (!open_v[idx]) begin
      exp_q.push_back('{t, 3'd2, bg, ba, row, col});
      cas = t + ACT_L;
    end else if (open_r[idx] != row) begin
      exp_q.push_back('{t, 3'd3, bg, ba, row, col});
      exp_q.push_back('{t + PRE_L, 3'd2, bg, ba, row, col});
      cas = t + PRE_L + ACT_L;
    end else cas = t;
    cas = (last_cas + GAP > cas) ? last_cas + GAP : cas;
    if (wr) cas = (last_rd + CL + GAP > cas) ? last_rd + CL + GAP : cas;
    if (burst > 0) cas = (e0 + burst + 1 > cas) ? e0 + burst + 1 : cas;
    exp_q.push_back('{cas, {2'b00, wr}, bg, ba, row, col});
    open_v[idx] = 1'b1;
    open_r[idx] = row;
    last_cas = cas;
    if (!wr) last_rd = cas;
    k = 0;
    while (evq.size() < exp_q.size() && k < 200) begin
      @(negedge clk_in);
      k++;
    end
    n_chk++;
    if (evq.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL event_count: got %0d strobes, required %0d", evq.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (evq.size() > 0) begin
      ev = evq.pop_front();
      n_chk++;
      if (ev.t != exp_q[i].t) begin
        n_fail++;
        $display("FAIL strobe_time[%0d]: cmd %0d at edge %0d, required edge %0d", i, ev.c, ev.t, exp_q[i].t);
      end
      n_chk++;
      if ({ev.c, ev.bg, ev.ba, ev.row, ev.col} !== {exp_q[i].c, exp_q[i].bg, exp_q[i].ba, exp_q[i].row, exp_q[i].col}) begin
        n_fail++;
        $display("FAIL strobe_fields[%0d]: cmd=%0d bg=%b ba=%0d row=%0d col=%0d, required cmd=%0d bg=%b ba=%0d row=%0d col=%0d",
                 i, ev.c, ev.bg, ev.ba, ev.row, ev.col, exp_q[i].c, exp_q[i].bg, exp_q[i].ba, exp_q[i].row, exp_q[i].col);
      end
    end
    evq.delete();
    if (wr) begin
      n_chk++;
      if (val_out !== d) begin
        n_fail++;
        $display("FAIL write_data: val_out=%h, required %h", val_out, d);
      end
    end
  endtask
  task automatic test_reset;
    apply_reset();
    check_reset_outputs("reset_state");
  endtask
  task automatic test_closed_read;
    do_req(1'b0, 2'd0, 8'd0, 4'd0, 1'b0, 0);
  endtask
  task automatic test_row_hit;
    do_req(1'b0, 2'd0, 8'd0, 4'd1, 1'b0, 0);
  endtask
  task automatic test_row_conflict;
    do_req(1'b0, 2'd0, 8'd2, 4'd0, 1'b0, 0);
  endtask
  task automatic test_write_after_read;
    do_req(1'b0, 2'd0, 8'd2, 4'd3, 1'b1, 0);
  endtask
  task automatic test_burst;
    do_req(1'b0, 2'd0, 8'd2, 4'd5, 1'b0, 10);
  endtask
  task automatic test_reset_mid;
    int k;
    apply_reset();
    req_valid_in = 1'b1;
    req_write_in = 1'b0;
    req_addr_in = mk_addr(1'b1, 2'd2, 8'h5A, 4'd3);
    @(negedge clk_in);
    req_valid_in = 1'b0;
    k = 0;
    while (evq.size() == 0 && k < 50) begin
      @(negedge clk_in);
      k++;
    end
    n_chk++;
    if (evq.size() != 1) begin
      n_fail++;
      $display("FAIL pre_reset_act: got %0d strobes, required 1", evq.size());
    end
    repeat (2) @(negedge clk_in);
    #2 rst_N_in = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk_in);
    rst_N_in = 1'b1;
    for (int i = 0; i < 8; i++) open_v[i] = 1'b0;
    last_cas = -1000;
    last_rd = -1000;
    evq.delete();
    do_req(1'b1, 2'd2, 8'h5A, 4'd3, 1'b0, 0);
  endtask
  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk_in);
      do_req(1'($urandom), 2'($urandom), 8'($urandom_range(0, 3)), 4'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0);
    end
  endtask
  task automatic test_quiet;
    repeat (10) @(negedge clk_in);
    n_chk++;
    if (evq.size() != 0) begin
      n_fail++;
      $display("FAIL stray_strobes: got %0d, required 0", evq.size());
    end
  endtask
  initial begin
    test_reset();
    test_closed_read();
    test_row_hit();
    test_row_conflict();
    test_write_after_read();
    test_burst();
    test_reset_mid();
    test_random();
    test_quiet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
